// File: rtl/vga_stream_checker_if.sv
// Stream bundle for vga_stream_checker: DUT and golden valid/data channels, ch0 at the LSBs.
interface vga_stream_checker_if #(
   parameter int NCH = 4,
   parameter int W   = 32
);
   logic             dut_valid;
   logic [NCH*W-1:0] dut_data;
   logic             gold_valid;
   logic [NCH*W-1:0] gold_data;

   modport master (output dut_valid, dut_data, gold_valid, gold_data);
   modport slave  (input  dut_valid, dut_data, gold_valid, gold_data);
endinterface

// File: rtl/vga_stream_checker.sv
// Multi-channel checker: compares DUT channels against a golden stream delayed by latency_i cycles.
// Optional VGA_CHK_XCHECK_EN (simulation only): 4-state compare, golden X/Z is don't-care, $error per error.
//  state  | meaning
//  IDLE   | waiting for enable_i, golden delay line held invalid
//  WARMUP | delay line filling for latency_i cycles, no compares
//  CHECK  | one compare per cycle with both valids high
//  HALT   | frozen after first error (STOP_ON_FAIL=1), left only by clear_i/reset
module vga_stream_checker #(
   parameter int  NCH          = 4,
   parameter int  W            = 32,
   parameter int  DEPTH        = 8,
   parameter int  CNT_W        = 16,
   parameter int  STOP_ON_FAIL = 0,
   localparam int LAT_W        = $clog2(DEPTH + 1),
   localparam int CH_W         = $clog2(NCH)
) (
   input  logic                 wb_clk_i,
   input  logic                 rst_i,
   input  logic                 enable_i,
   input  logic                 clear_i,
   input  logic [LAT_W-1:0]     latency_i,
   input  logic [NCH-1:0]       chan_mask_i,
   vga_stream_checker_if.slave  stream_if,
   output logic [1:0]           state_o,
   output logic                 fail_o,
   output logic [NCH*CNT_W-1:0] err_cnt_o,
   output logic [CNT_W-1:0]     sync_err_o,
   output logic [31:0]          checks_o,
   output logic [CH_W-1:0]      first_chan_o,
   output logic [31:0]          first_cyc_o,
   output logic [W-1:0]         first_dut_o,
   output logic [W-1:0]         first_gold_o
);

   localparam logic [1:0] S_IDLE   = 2'b00;
   localparam logic [1:0] S_WARMUP = 2'b01;
   localparam logic [1:0] S_CHECK  = 2'b10;
   localparam logic [1:0] S_HALT   = 2'b11;

   logic [1:0]       state_q, state_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [LAT_W-1:0] wcnt_q, wcnt_d;

   logic [DEPTH-1:0] dly_v_q;
   logic [NCH*W-1:0] dly_d_q [DEPTH];
   logic             gold_v_dly;
   logic [NCH*W-1:0] gold_d_dly;

   logic [CNT_W-1:0] err_cnt_q [NCH];
   logic [CNT_W-1:0] err_cnt_d [NCH];
   logic [CNT_W-1:0] sync_q, sync_d;
   logic [31:0]      checks_q, checks_d;
   logic             fail_q, fail_d;
   logic [CH_W-1:0]  first_chan_q, first_chan_d;
   logic [31:0]      first_cyc_q, first_cyc_d;
   logic [W-1:0]     first_dut_q, first_dut_d;
   logic [W-1:0]     first_gold_q, first_gold_d;

   logic             check_act;
   logic             cmp_fire;
   logic             sync_fire;
   logic             err_any;
   logic [NCH-1:0]   ch_neq;
   logic [NCH-1:0]   ch_err;

   // lat_q outside 1..DEPTH falls back to the bypass path
   always_comb begin
      gold_v_dly = stream_if.gold_valid;
      gold_d_dly = stream_if.gold_data;
      for (int i = 0; i < DEPTH; i++) begin
         if (lat_q == LAT_W'(i + 1)) begin
            gold_v_dly = dly_v_q[i];
            gold_d_dly = dly_d_q[i];
         end
      end
   end

`ifdef VGA_CHK_XCHECK_EN
   always_comb begin
      ch_neq = '0;
      for (int c = 0; c < NCH; c++) begin
         for (int b = 0; b < W; b++) begin
            if (!$isunknown(gold_d_dly[c*W + b]) &&
                (stream_if.dut_data[c*W + b] !== gold_d_dly[c*W + b]))
               ch_neq[c] = 1'b1;
         end
      end
   end
`else
   always_comb begin
      ch_neq = '0;
      for (int c = 0; c < NCH; c++)
         ch_neq[c] = (stream_if.dut_data[c*W +: W] != gold_d_dly[c*W +: W]);
   end
`endif

   assign check_act = (state_q == S_CHECK) && enable_i && !clear_i;
   assign cmp_fire  = check_act && stream_if.dut_valid && gold_v_dly;
   assign sync_fire = check_act && (stream_if.dut_valid != gold_v_dly);
   assign ch_err    = cmp_fire ? (ch_neq & chan_mask_i) : '0;
   assign err_any   = sync_fire || (|ch_err);

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      wcnt_d  = wcnt_q;
      if (clear_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable_i) begin
                  lat_d   = latency_i;
                  wcnt_d  = latency_i - LAT_W'(1);
                  state_d = (latency_i == '0) ? S_CHECK : S_WARMUP;
               end
            end
            S_WARMUP: begin
               if (!enable_i)
                  state_d = S_IDLE;
               else if (wcnt_q == '0)
                  state_d = S_CHECK;
               else
                  wcnt_d = wcnt_q - LAT_W'(1);
            end
            S_CHECK: begin
               if (!enable_i)
                  state_d = S_IDLE;
               else if ((STOP_ON_FAIL != 0) && err_any)
                  state_d = S_HALT;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      err_cnt_d    = err_cnt_q;
      sync_d       = sync_q;
      checks_d     = checks_q;
      fail_d       = fail_q;
      first_chan_d = first_chan_q;
      first_cyc_d  = first_cyc_q;
      first_dut_d  = first_dut_q;
      first_gold_d = first_gold_q;
      if (clear_i) begin
         for (int c = 0; c < NCH; c++)
            err_cnt_d[c] = '0;
         sync_d       = '0;
         checks_d     = '0;
         fail_d       = 1'b0;
         first_chan_d = '0;
         first_cyc_d  = '0;
         first_dut_d  = '0;
         first_gold_d = '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (ch_err[c] && (err_cnt_q[c] != '1))
               err_cnt_d[c] = err_cnt_q[c] + CNT_W'(1);
         end
         if (sync_fire && (sync_q != '1))
            sync_d = sync_q + CNT_W'(1);
         if (cmp_fire)
            checks_d = checks_q + 32'd1;
         // a sync-only error leaves channel and values at zero
         if (err_any && !fail_q) begin
            fail_d       = 1'b1;
            first_cyc_d  = checks_q;
            first_chan_d = '0;
            first_dut_d  = '0;
            first_gold_d = '0;
            for (int c = NCH - 1; c >= 0; c--) begin
               if (ch_err[c]) begin
                  first_chan_d = CH_W'(c);
                  first_dut_d  = stream_if.dut_data[c*W +: W];
                  first_gold_d = gold_d_dly[c*W +: W];
               end
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge rst_i) begin
      if (!rst_i) begin
         dly_v_q <= '0;
         for (int i = 0; i < DEPTH; i++)
            dly_d_q[i] <= '0;
      end else if (state_d == S_IDLE) begin
         dly_v_q <= '0;
      end else begin
         dly_v_q[0] <= stream_if.gold_valid;
         dly_d_q[0] <= stream_if.gold_data;
         for (int i = 1; i < DEPTH; i++) begin
            dly_v_q[i] <= dly_v_q[i-1];
            dly_d_q[i] <= dly_d_q[i-1];
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= S_IDLE;
         lat_q        <= '0;
         wcnt_q       <= '0;
         for (int c = 0; c < NCH; c++)
            err_cnt_q[c] <= '0;
         sync_q       <= '0;
         checks_q     <= '0;
         fail_q       <= 1'b0;
         first_chan_q <= '0;
         first_cyc_q  <= '0;
         first_dut_q  <= '0;
         first_gold_q <= '0;
      end else begin
         state_q      <= state_d;
         lat_q        <= lat_d;
         wcnt_q       <= wcnt_d;
         err_cnt_q    <= err_cnt_d;
         sync_q       <= sync_d;
         checks_q     <= checks_d;
         fail_q       <= fail_d;
         first_chan_q <= first_chan_d;
         first_cyc_q  <= first_cyc_d;
         first_dut_q  <= first_dut_d;
         first_gold_q <= first_gold_d;
      end
   end

`ifdef VGA_CHK_XCHECK_EN
   always @(posedge wb_clk_i) begin
      for (int c = 0; c < NCH; c++) begin
         if (ch_err[c])
            $error("vga_stream_checker: ch%0d check %0d dut %h gold %h", c, checks_q,
                   stream_if.dut_data[c*W +: W], gold_d_dly[c*W +: W]);
      end
   end
`endif

   always_comb begin
      err_cnt_o = '0;
      for (int c = 0; c < NCH; c++)
         err_cnt_o[c*CNT_W +: CNT_W] = err_cnt_q[c];
   end

   assign state_o      = state_q;
   assign fail_o       = fail_q;
   assign sync_err_o   = sync_q;
   assign checks_o     = checks_q;
   assign first_chan_o = first_chan_q;
   assign first_cyc_o  = first_cyc_q;
   assign first_dut_o  = first_dut_q;
   assign first_gold_o = first_gold_q;

endmodule
